// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI serial-clock engine
package spi_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    // SPI modes as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int MIN_HALF = 2;

endpackage

// File: rtl/spi_half_timer.sv
// rtl/spi_half_timer.sv - half-period counter, terminal pulse every i_load enabled cycles
module spi_half_timer #(
    parameter int W = 8
) (
    input  logic         i_clk_sys,
    input  logic         i_rst,
    input  logic [W-1:0] i_load,
    input  logic         i_en,
    input  logic         i_clear,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_last;

    assign w_last = i_load - {{(W-1){1'b0}}, 1'b1};
    assign o_tc   = i_en && !i_clear && (r_cnt == w_last);

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_sclk_engine.sv
// rtl/spi_sclk_engine.sv - SPI SCLK generator with mode-aware shift/sample strobes
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter int   DIV_W    = 8,
    parameter int   CNT_W    = 6,
    parameter logic RST_CPOL = 1'b0
) (
    input  logic             i_clk_sys,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_cpol,
    input  logic             i_cpha,
    input  logic [DIV_W-1:0] i_half_div,
    input  logic [CNT_W-1:0] i_nbits,
    output logic             o_sclk,
    output logic             o_shift,
    output logic             o_sample,
    output logic [CNT_W-1:0] o_bit_idx,
    output logic             o_busy,
    output logic             o_done
);

    logic [1:0]       r_state;
    logic             r_cpol;
    logic             r_cpha;
    logic [CNT_W-1:0] r_nbits;
    logic [DIV_W-1:0] r_half;
    logic [CNT_W:0]   r_edge;
    logic             r_sclk;
    logic             r_shift;
    logic             r_sample;
    logic [CNT_W-1:0] r_bit_idx;
    logic             r_busy;
    logic             r_done;

    logic             w_idle;
    logic             w_accept;
    logic             w_tc;
    logic             w_run_tc;
    logic [DIV_W-1:0] w_half_cl;
    logic [CNT_W:0]   w_edge_nxt;
    logic             w_lead;
    logic             w_last_edge;
    logic             w_shift_ev;
    logic             w_sample_ev;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = w_idle && i_start && (i_nbits != '0);
    assign w_half_cl   = (i_half_div < DIV_W'(MIN_HALF)) ? DIV_W'(MIN_HALF) : i_half_div;
    assign w_run_tc    = w_tc && (r_state == ST_RUN);
    assign w_edge_nxt  = r_edge + 1'b1;
    assign w_lead      = w_edge_nxt[0];
    assign w_last_edge = (w_edge_nxt == {r_nbits, 1'b0});

    // CPHA=0 launches bit 0 at accept, so the final trailing edge carries no shift
    assign w_sample_ev = w_run_tc && (r_cpha ? !w_lead : w_lead);
    assign w_shift_ev  = w_run_tc && (r_cpha ? w_lead : (!w_lead && !w_last_edge));

    // One timer serves both the SCLK half-periods and the chip-select hold in TAIL
    spi_half_timer #(
        .W (DIV_W)
    ) u_half_timer (
        .i_clk_sys (i_clk_sys),
        .i_rst     (i_rst),
        .i_load    (r_half),
        .i_en      (!w_idle),
        .i_clear   (w_idle),
        .o_tc      (w_tc)
    );

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_nbits   <= '0;
            r_half    <= '0;
            r_edge    <= '0;
            r_sclk    <= RST_CPOL;
            r_shift   <= 1'b0;
            r_sample  <= 1'b0;
            r_bit_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_shift  <= w_shift_ev;
            r_sample <= w_sample_ev;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sclk <= i_cpol;
                    if (w_accept) begin
                        r_cpol    <= i_cpol;
                        r_cpha    <= i_cpha;
                        r_nbits   <= i_nbits;
                        r_half    <= w_half_cl;
                        r_edge    <= '0;
                        r_bit_idx <= '0;
                        r_busy    <= 1'b1;
                        r_shift   <= !i_cpha;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tc) begin
                        r_sclk <= w_last_edge ? r_cpol : ~r_sclk;
                        r_edge <= w_edge_nxt;
                        if (w_sample_ev) begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                        if (w_last_edge) begin
                            r_state <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (w_tc) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sclk    = r_sclk;
    assign o_shift   = r_shift;
    assign o_sample  = r_sample;
    assign o_bit_idx = r_bit_idx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule
